// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops and
// iterative one-bit-per-cycle shifts behind a valid/ready handshake.
module alu_execute #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_decode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [3:0] {
        OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_SLL = 4'd3,
        OP_SLT = 4'd4, OP_SLTU = 4'd5, OP_SUB = 4'd6, OP_XOR = 4'd7,
        OP_SRL = 4'd8, OP_SRA = 4'd9
    } op_t;
    typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

    state_t          state, state_next;
    kind_t           kind, kind_dec;
    logic [XLEN-1:0] shreg, shreg_step, alu_res;
    logic [SHW-1:0]  count, amount;
    logic            is_shift, accept, consume, load_shift, finish;

    assign amount   = op_b[SHW-1:0];
    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign busy     = (state == SHIFT);

    // Shift ops report op_a here so an amount of zero completes in one cycle.
    always_comb begin
        alu_res  = '0;
        is_shift = 1'b0;
        kind_dec = K_SLL;
        case (alu_decode)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_SLL: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_dec = K_SLL;
            end
            OP_SRL: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_dec = K_SRL;
            end
            OP_SRA: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_dec = K_SRA;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (kind)
            K_SLL:   shreg_step = {shreg[XLEN-2:0], 1'b0};
            K_SRL:   shreg_step = {1'b0, shreg[XLEN-1:1]};
            default: shreg_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_next = state;
        load_shift = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_shift && (amount != '0)) begin
                    load_shift = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            count     <= '0;
            kind      <= K_SLL;
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (load_shift) begin
                shreg <= op_a;
                count <= amount;
                kind  <= kind_dec;
            end else if (state == SHIFT) begin
                shreg <= shreg_step;
                count <= count - SHW'(1);
            end

            if (finish) begin
                result    <= shreg_step;
                zero      <= (shreg_step == '0);
                out_valid <= 1'b1;
            end else if (accept && !load_shift) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_execute.sv
// Bench for alu_execute: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_execute;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_decode = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    int total = 0;
    int passed = 0;

    alu_execute #(.XLEN(32), .SHW(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_decode(alu_decode), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        int sh;
        sa = a;
        sh = int'(b % 32);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a << sh;
            4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5: return (a < b) ? 32'd1 : 32'd0;
            4'd6: return a - b;
            4'd7: return a ^ b;
            4'd8: return a >> sh;
            4'd9: return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd3 || op == 4'd8 || op == 4'd9) return int'(b % 32);
        return 0;
    endfunction

    // Reference model: an accepted op either lands at once or after a
    // countdown equal to its shift amount.
    logic        m_valid = 1'b0;
    logic        m_zero = 1'b1;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;
    int          m_left = 0;
    logic        m_ready;

    assign m_ready = (m_left == 0) && (!m_valid || out_ready);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_result <= '0;
            m_zero   <= 1'b1;
            m_left   <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid  <= 1'b1;
                m_result <= m_pend;
                m_zero   <= (m_pend == 0);
            end
        end else if (in_valid && m_ready) begin
            if (ref_lat(alu_decode, op_b) == 0) begin
                m_valid  <= 1'b1;
                m_result <= ref_op(alu_decode, op_a, op_b);
                m_zero   <= (ref_op(alu_decode, op_a, op_b) == 0);
            end else begin
                m_left  <= ref_lat(alu_decode, op_b);
                m_pend  <= ref_op(alu_decode, op_a, op_b);
                m_valid <= 1'b0;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clock) begin
        check("model_out_valid", 32'(out_valid), 32'(m_valid));
        check("model_busy", 32'(busy), 32'(m_left > 0));
        check("model_in_ready", 32'(in_ready), 32'(m_ready));
        if (m_valid) begin
            check("model_result", result, m_result);
            check("model_zero", 32'(zero), 32'(m_zero));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 0;
        alu_decode = op;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (in_ready) begin
                done = 1;
                break;
            end
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        bit found;
        found = 0;
        lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (out_valid) begin
                found = 1;
                break;
            end
            lat++;
        end
        if (!found) check("result_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #2 reset = 1'b0;

        issue(4'd2, 32'h7FFF_FFFF, 32'd1);
        wait_result(lat);
        check("add_latency", lat, 32'd0);
        check("add_result", result, 32'h8000_0000);
        check("add_zero", 32'(zero), 32'd0);

        issue(4'd6, 32'h1234, 32'h1234);
        wait_result(lat);
        check("sub_result", result, 32'd0);
        check("sub_zero", 32'(zero), 32'd1);

        issue(4'd4, 32'hFFFF_FFFF, 32'd1);
        wait_result(lat);
        check("slt_result", result, 32'd1);

        issue(4'd5, 32'hFFFF_FFFF, 32'd1);
        wait_result(lat);
        check("sltu_result", result, 32'd0);

        issue(4'd9, 32'h8000_0000, 32'h3F);
        wait_result(lat);
        check("sra_latency", lat, 32'd31);
        check("sra_result", result, 32'hFFFF_FFFF);

        issue(4'd8, 32'h8000_0000, 32'h3F);
        wait_result(lat);
        check("srl_latency", lat, 32'd31);
        check("srl_result", result, 32'h0000_0001);

        issue(4'd3, 32'd1, 32'd0);
        wait_result(lat);
        check("sll0_latency", lat, 32'd0);
        check("sll0_result", result, 32'd1);

        issue(4'd8, 32'hF000_000F, 32'hFFFF_FF24);
        wait_result(lat);
        check("srl4_latency", lat, 32'd4);
        check("srl4_result", result, 32'h0F00_0000);

        // Backpressure: hold XOR result, AND waits until out_ready rises.
        issue(4'd7, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
        out_ready = 1'b0;
        alu_decode = 4'd0;
        op_a = 32'h1234_5678;
        op_b = 32'h0000_FFFF;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", result, 32'hF0F0_F0F0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_result", result, 32'hF0F0_F0F0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check("bp_and_result", result, 32'h0000_5678);

        // Abort a shift part-way with an asynchronous reset.
        issue(4'd3, 32'd1, 32'd20);
        repeat (4) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;

        issue(4'd2, 32'd2, 32'd3);
        wait_result(lat);
        check("post_reset_add", result, 32'd5);

        issue(4'd12, 32'd5, 32'd5);
        wait_result(lat);
        check("illegal_latency", lat, 32'd0);
        check("illegal_result", result, 32'd0);
        check("illegal_zero", 32'(zero), 32'd1);

        @(posedge clock);
        #1;
        in_valid = 1'b1;
        alu_decode = 4'd1;
        op_a = 32'd1 << 8;
        op_b = 32'd1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (i < 7) begin
                op_a = 32'(i + 2) << 8;
                op_b = 32'(i + 2);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            check("tput_valid", 32'(out_valid), 32'd1);
            check("tput_result", result, (32'(i + 1) << 8) | 32'(i + 1));
        end

        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_execute.md
# alu_execute

Execute-stage arithmetic unit that consumes the 4-bit `alu_decode` operation code produced by ALU control and performs the operation on two XLEN-bit operands. Sits in EX after ALU control; the result goes to the EX/MEM register. Logic/arithmetic/compare operations complete in one cycle. Shifts run iteratively, one bit per cycle, trading latency for area. A valid/ready handshake on both sides lets the hazard unit stall the pipeline on a shift.

## Interface
- XLEN, 32, operand and result width
- SHW, 5, shift-amount width, equal to log2(XLEN)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- alu_decode  in  4  operation code (table under Operation)
- op_a  in  XLEN  operand A (shift source)
- op_b  in  XLEN  operand B (shift amount = op_b[SHW-1:0])
- out_valid  out  1  result available
- out_ready  in  1  downstream consumes result
- result  out  XLEN  operation result
- zero  out  1  result == 0, registered alongside result
- busy  out  1  iterative shift in progress; pipeline stall request

## Operation
- Codes:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 SLL
  - 4 SLT (signed, result 0/1)
  - 5 SLTU (unsigned, result 0/1)
  - 6 SUB
  - 7 XOR
  - 8 SRL
  - 9 SRA
  - 10–15 illegal: result 0, zero 1, single-cycle.
- ADD/SUB wrap modulo 2^XLEN; no carry/overflow output.
- SLT compares two's complement; SLTU compares unsigned.
- Only op_b[SHW-1:0] is used for shifts; upper bits are ignored.
- FSM states: IDLE, SHIFT.
  - IDLE, accept of a non-shift op: result and zero register at the edge; out_valid set; stay IDLE.
  - IDLE, accept of a shift with amount 0: result = op_a, single-cycle; stay IDLE.
  - IDLE, accept of a shift with amount n>0: load shift register with op_a, counter with n, latch the kind (SLL/SRL/SRA); go to SHIFT; busy=1.
  - SHIFT: each cycle shift by 1 bit.
    - SLL fills 0 at the LSB.
    - SRL fills 0 at the MSB.
    - SRA replicates the MSB.
    - Decrement counter. On the cycle the counter goes 1→0: result = shifted value, zero updated, out_valid set, return to IDLE, busy=0.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - out_valid holds, with result and zero stable, until out_valid & out_ready.
  - A simultaneous consume and accept in the same cycle is legal; out_valid stays 1 with the new result.
  - Consume without a new accept: out_valid clears next edge.
- Inputs are sampled only at accept; changes to alu_decode/op_a/op_b during SHIFT have no effect.
- in_valid is ignored while in_ready=0. The upstream holds the operation; no drop occurs.

## Timing
- Reset values: state IDLE; out_valid 0; result 0; zero 1; busy 0; counter 0. in_ready is 1 after reset.
- Reset asserted mid-shift aborts the operation immediately (asynchronous), with no result produced.
- Non-shift latency: accept at edge k → out_valid=1 after edge k.
- Shift by n>0:
  - busy=1 after the accept edge.
  - out_valid=1 after edge k+n.
  - in_ready=0 for n cycles.
- Back-to-back single-cycle ops with out_ready=1 sustain 1 op/cycle.
- Maximum shift latency is XLEN-1 = 31 cycles.
- No combinational path from op_a/op_b/alu_decode to outputs. out_ready→in_ready is the only combinational path.

## Test plan
- Reset then ADD: alu_decode=2, op_a=0x7FFFFFFF, op_b=1 → next cycle result=0x80000000, zero=0, out_valid=1.
- SUB/zero: alu_decode=6, op_a=op_b=0x1234 → result=0, zero=1. SLT with op_a=0xFFFFFFFF, op_b=1 → 1. SLTU with the same operands → 0.
- SRA iterative: alu_decode=9, op_a=0x80000000, op_b=0x3F (amount 31) → in_ready=0 and busy=1 for 31 cycles, then result=0xFFFFFFFF. SRL with the same inputs → 0x00000001. SLL of 1 by 0 → 1 after one cycle.
- Backpressure: out_ready=0 after an XOR result of 0xF0F0F0F0; present a new AND → in_ready=0, result stays 0xF0F0F0F0. Raise out_ready → the AND is accepted in the same cycle and its result appears the next cycle.
- Reset mid-shift: SLL by 20, assert reset at cycle 5 → out_valid=0, busy=0, result=0 immediately. After release, an ADD 2+3 → 5.
- Illegal code 12 with op_a=5, op_b=5 → result=0, zero=1, latency 1. Throughput check: 8 consecutive OR ops with out_ready=1 → 8 results on 8 consecutive cycles.
